// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bundle between next-PC logic and the program counter.
// Latency: none (signal bundle only).
// Backpressure: stall holds the PC; halt_req/resume park and restart fetch.
// Ports/modports:
//   master - next-PC/control side: drives stall, halt_req, resume, redirect_*, trap_*;
//            observes pc, pc_plus_inc, pc_valid, epc, misaligned_fault, state.
//   slave  - pc_unit side: the mirror image of master.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            halt_req;
  logic            resume;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            trap_return;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_inc;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic            misaligned_fault;
  logic [1:0]      state;

  modport master (
    output stall, halt_req, resume, redirect_valid, redirect_target, trap_req, trap_return,
    input  pc, pc_plus_inc, pc_valid, epc, misaligned_fault, state
  );

  modport slave (
    input  stall, halt_req, resume, redirect_valid, redirect_target, trap_req, trap_return,
    output pc, pc_plus_inc, pc_valid, epc, misaligned_fault, state
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: RV32I program counter with redirect, trap entry/return and a BOOT/RUN/HALT FSM.
// Latency: pc updates one cycle after the controlling input; pc_plus_inc is same-cycle.
// Backpressure: stall holds pc in RUN; control-flow changes override stall; HALT parks fetch.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, dominates all other inputs
//   bus  - pc_unit_if.slave: control inputs in, pc/epc/pc_valid/fault/state out
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // INC is a power of two, so the low bits of INC-1 form the alignment mask.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_fault;
  logic            r_pc_valid;

  logic [XLEN-1:0] w_pc_plus_inc;
  logic            w_misaligned;

  // Natural XLEN-bit addition gives the required wrap at the top of the address space.
  assign w_pc_plus_inc = r_pc + XLEN'(INC);
  assign w_misaligned  = |(bus.redirect_target & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_epc      <= '0;
      r_fault    <= 1'b0;
      r_pc_valid <= 1'b0;
    end else begin
      // Fault flag is a one-cycle pulse; only the faulting RUN branch re-raises it.
      r_fault <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end

        ST_RUN: begin
          // Priority chain: trap, trap return, misaligned redirect, redirect, stall, increment.
          if (bus.trap_req) begin
            r_epc <= r_pc;
            r_pc  <= TRAP_VECTOR;
          end else if (bus.trap_return) begin
            r_pc <= r_epc;
          end else if (bus.redirect_valid && w_misaligned) begin
            r_epc   <= r_pc;
            r_pc    <= TRAP_VECTOR;
            r_fault <= 1'b1;
          end else if (bus.redirect_valid) begin
            r_pc <= bus.redirect_target;
          end else if (!bus.stall) begin
            r_pc <= w_pc_plus_inc;
          end
          // Halt takes effect after this cycle's pc update has been applied.
          if (bus.halt_req) begin
            r_state    <= ST_HALT;
            r_pc_valid <= 1'b0;
          end
        end

        ST_HALT: begin
          // Traps are still taken while parked; everything else except resume is ignored.
          if (bus.trap_req) begin
            r_epc <= r_pc;
            r_pc  <= TRAP_VECTOR;
          end
          if (bus.resume) begin
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
          end
        end

        default: begin
          r_state    <= ST_BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc               = r_pc;
  assign bus.pc_plus_inc      = w_pc_plus_inc;
  assign bus.pc_valid         = r_pc_valid;
  assign bus.epc              = r_epc;
  assign bus.misaligned_fault = r_fault;
  assign bus.state            = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic checked against a behavioural model.
// Latency: model advances once per rising edge; outputs are compared 1 time unit after it.
// Backpressure: stall/halt/resume are driven directly from the stimulus.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk;
  logic rst;

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN        (32),
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV),
    .INC         (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: mode 0=boot, 1=run, 2=halt.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_fault;
  int          m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] add_wrap(input logic [31:0] a, input longint b);
    longint s;
    s = (longint'(a) + b) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  // Next-state rules evaluated on the values present at the edge.
  task automatic model_edge();
    if (rst) begin
      m_pc = RV; m_epc = 0; m_fault = 0; m_mode = 0;
      return;
    end
    m_fault = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.trap_req) begin
        m_epc = m_pc; m_pc = TV;
      end else if (bus.trap_return) begin
        m_pc = m_epc;
      end else if (bus.redirect_valid && (bus.redirect_target % 4 != 0)) begin
        m_epc = m_pc; m_pc = TV; m_fault = 1;
      end else if (bus.redirect_valid) begin
        m_pc = bus.redirect_target;
      end else if (!bus.stall) begin
        m_pc = add_wrap(m_pc, 4);
      end
      if (bus.halt_req) m_mode = 2;
    end else begin
      if (bus.trap_req) begin
        m_epc = m_pc; m_pc = TV;
      end
      if (bus.resume) m_mode = 1;
    end
  endtask

  task automatic check_all();
    chk("pc",          bus.pc,                       m_pc);
    chk("pc_plus_inc", bus.pc_plus_inc,              add_wrap(m_pc, 4));
    chk("pc_valid",    {31'd0, bus.pc_valid},        {31'd0, m_mode == 1});
    chk("epc",         bus.epc,                      m_epc);
    chk("fault",       {31'd0, bus.misaligned_fault}, {31'd0, m_fault});
    chk("state",       {30'd0, bus.state},           32'(m_mode));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic st, input logic hq, input logic rs,
                       input logic rv_i, input logic [31:0] tgt, input logic tq, input logic tr);
    rst                 = r;
    bus.stall           = st;
    bus.halt_req        = hq;
    bus.resume          = rs;
    bus.redirect_valid  = rv_i;
    bus.redirect_target = tgt;
    bus.trap_req        = tq;
    bus.trap_return     = tr;
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
    // Reset to BOOT, then four RUN cycles.
    chk("t1_boot_pc",    bus.pc, 32'h0);
    chk("t1_boot_valid", {31'd0, bus.pc_valid}, 32'd0);
    chk("t1_boot_state", {30'd0, bus.state}, 32'd0);
    idle(); chk("t1_pc0", bus.pc, 32'h0); chk("t1_state", {30'd0, bus.state}, 32'd1);
    idle(); chk("t1_pc4", bus.pc, 32'h4);
    idle(); chk("t1_pc8", bus.pc, 32'h8);
    idle(); chk("t1_pc12", bus.pc, 32'hC);

    // Stall then redirect, from pc=8.
    drive(0, 0, 0, 0, 1, 32'h8, 0, 0); chk("t2_pc8", bus.pc, 32'h8);
    drive(0, 1, 0, 0, 0, 32'h0, 0, 0); chk("t2_hold1", bus.pc, 32'h8);
    drive(0, 1, 0, 0, 0, 32'h0, 0, 0); chk("t2_hold2", bus.pc, 32'h8);
    drive(0, 1, 0, 0, 1, 32'h40, 0, 0); chk("t2_redir", bus.pc, 32'h40);
    idle(); chk("t2_next", bus.pc, 32'h44);

    // Misaligned redirect at 0x44, then mret.
    drive(0, 0, 0, 0, 1, 32'h42, 0, 0);
    chk("t3_pc", bus.pc, TV); chk("t3_epc", bus.epc, 32'h44);
    chk("t3_fault", {31'd0, bus.misaligned_fault}, 32'd1);
    drive(0, 0, 0, 0, 0, 32'h0, 0, 1);
    chk("t3_ret", bus.pc, 32'h44);
    chk("t3_fault_gone", {31'd0, bus.misaligned_fault}, 32'd0);

    // Trap beats a simultaneous redirect.
    drive(0, 0, 0, 0, 1, 32'h10, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h80, 1, 0);
    chk("t4_pc", bus.pc, TV); chk("t4_epc", bus.epc, 32'h10);
    chk("t4_nofault", {31'd0, bus.misaligned_fault}, 32'd0);

    // Halt at 0x20, noise while halted, resume.
    drive(0, 0, 0, 0, 1, 32'h20, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
    chk("t5_pc", bus.pc, 32'h24); chk("t5_state", {30'd0, bus.state}, 32'd2);
    chk("t5_valid", {31'd0, bus.pc_valid}, 32'd0);
    drive(0, 1, 1, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h200, 0, 0);
    drive(0, 0, 1, 0, 1, 32'h43, 0, 0);
    chk("t5_held", bus.pc, 32'h24);
    drive(0, 0, 0, 1, 0, 32'h0, 0, 0);
    chk("t5_resume_pc", bus.pc, 32'h24); chk("t5_resume_state", {30'd0, bus.state}, 32'd1);
    idle(); chk("t5_next", bus.pc, 32'h28);

    // Wrap at top of address space, trap while halted, reset from HALT.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("t6_top_plus", bus.pc_plus_inc, 32'h0);
    idle(); chk("t6_wrap", bus.pc, 32'h0);
    drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
    chk("t6_halt_trap_pc", bus.pc, TV); chk("t6_halt_trap_epc", bus.epc, 32'h4);
    chk("t6_halt_trap_state", {30'd0, bus.state}, 32'd2);
    drive(1, 0, 0, 0, 1, 32'h80, 1, 0);
    chk("t6_rst_state", {30'd0, bus.state}, 32'd0);
    chk("t6_rst_pc", bus.pc, 32'h0); chk("t6_rst_epc", bus.epc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            tgt,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
